caravel_user_fir: RTL and testbench

Wishbone-slave 11-tap FIR accelerator in the Caravel user project area. Firmware on the management core programs the taps, the length and the ap_ctrl register, then streams samples in and results out over Wishbone. A firmware-written 16-bit checkbits register drives mprj_io[31:16] so the testbench can detect progress markers, e.g. 0xAB40 at start and 0xAB51 at end.

---
 rtl/fir_pkg.sv | 42 ++++
 rtl/fir_mac_datapath.sv | 76 +++++++
 rtl/caravel_user_fir.sv | 173 +++++++++++++++++
 tb/tb_caravel_user_fir.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, register map and types for the Caravel user-area FIR accelerator.
package fir_pkg;

  localparam int NUM_TAPS = 11;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;

  // Tap counter value for the final accumulate-only cycle.
  localparam idx_t MAC_LAST = idx_t'(NUM_TAPS);

  localparam logic [7:0] OFF_AP_CTRL   = 8'h00;
  localparam logic [7:0] OFF_DATA_LEN  = 8'h10;
  localparam logic [7:0] OFF_CHECKBITS = 8'h14;
  localparam logic [7:0] OFF_X_IN      = 8'h80;
  localparam logic [7:0] OFF_Y_OUT     = 8'h84;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_X,
    S_MAC,
    S_WAIT_Y
  } state_e;

  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input logic [DATA_W/8-1:0] sel);
    word_t r;
    r = old_w;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Low DATA_W bits of a signed product are the two's-complement wrapped result.
  function automatic word_t mul_wrap(input word_t a, input word_t b);
    return word_t'($signed(a) * $signed(b));
  endfunction

endpackage

// File: rtl/fir_mac_datapath.sv
// Sample history, tap counter and multiply-accumulate for one FIR output.
// The product is registered ahead of the adder, so a run spans 12 cycles after the shift.
module fir_mac_datapath
  import fir_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear_i,
  input  logic  shift_i,
  input  word_t x_i,
  input  word_t taps_i [NUM_TAPS],
  output logic  last_o,
  output word_t y_o
);

  word_t hist_q [NUM_TAPS];
  word_t hist_d [NUM_TAPS];
  idx_t  idx_q, idx_d;
  logic  busy_q, busy_d;
  word_t prod_q, prod_d;
  word_t acc_q, acc_d;
  word_t y_q, y_d;

  assign last_o = busy_q && (idx_q == MAC_LAST);
  assign y_o    = y_q;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block infers a latch.
    hist_d = hist_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    prod_d = prod_q;
    acc_d  = acc_q;
    y_d    = y_q;

    if (clear_i) hist_d = '{default: '0};

    if (shift_i) begin
      hist_d[0] = x_i;
      for (int i = 1; i < NUM_TAPS; i++) hist_d[i] = hist_q[i-1];
      idx_d  = '0;
      busy_d = 1'b1;
      acc_d  = '0;
    end else if (busy_q) begin
      idx_d = idx_q + idx_t'(1);
      if (idx_q != MAC_LAST) prod_d = mul_wrap(taps_i[idx_q], hist_q[idx_q]);
      if (idx_q != '0)       acc_d  = acc_q + prod_q;
      if (last_o) begin
        y_d    = acc_q + prod_q;
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the history is a register file but must still be reset, since a run
      // after reset has to start from an all-zero past.
      hist_q <= '{default: '0};
      idx_q  <= '0;
      busy_q <= 1'b0;
      prod_q <= '0;
      acc_q  <= '0;
      y_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      hist_q <= hist_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
      y_q    <= y_d;
    end
  end

endmodule

// File: rtl/caravel_user_fir.sv
// Wishbone-slave 11-tap FIR: register decode, control FSM and checkbits.
// Define FIR_IRQ_EN to drive irq_o from ap_done; otherwise irq_o is tied low.
module caravel_user_fir
  import fir_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] io_out,
  output logic        irq_o
);

  state_e      state_q, state_d;
  logic        done_q, done_d;
  word_t       len_q, len_d;
  word_t       cnt_q, cnt_d;
  logic [15:0] chk_q, chk_d;
  word_t       taps_q [NUM_TAPS];
  word_t       taps_d [NUM_TAPS];
  logic        ack_q, ack_d;
  word_t       dat_q, dat_d;

  logic [7:0] off;
  logic       tap_hit, stall, req, wr_fire, rd_fire;
  idx_t       tap_sel;
  logic       done_set, done_clr, mac_clear, mac_shift, mac_last;
  word_t      mac_y;
  logic       unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  fir_mac_datapath u_mac (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear_i (mac_clear),
    .shift_i (mac_shift),
    .x_i     (wbs_dat_i),
    .taps_i  (taps_q),
    .last_o  (mac_last),
    .y_o     (mac_y)
  );

  always_comb begin
    off     = {wbs_adr_i[7:2], 2'b00};
    tap_sel = off[5:2];
    tap_hit = (off[7:6] == 2'b01) && (tap_sel < MAC_LAST);
    // Data-port accesses outside their state are held off rather than dropped.
    stall   = ( wbs_we_i && off == OFF_X_IN  && state_q != S_WAIT_X) ||
              (!wbs_we_i && off == OFF_Y_OUT && state_q != S_WAIT_Y);
    req     = wbs_cyc_i && wbs_stb_i && !ack_q &&
              (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    wr_fire = req && !stall && wbs_we_i;
    rd_fire = req && !stall && !wbs_we_i;

    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    taps_d    = taps_q;
    ack_d     = wr_fire || rd_fire;
    dat_d     = '0;
    done_set  = 1'b0;
    done_clr  = 1'b0;
    mac_clear = 1'b0;
    mac_shift = 1'b0;

    if (wr_fire && state_q == S_IDLE) begin
      if (off == OFF_DATA_LEN) len_d = wbs_dat_i;
      if (tap_hit) taps_d[tap_sel] = merge_bytes(taps_q[tap_sel], wbs_dat_i, wbs_sel_i);
    end
    if (wr_fire && off == OFF_CHECKBITS) begin
      if (wbs_sel_i[0]) chk_d[7:0]  = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) chk_d[15:8] = wbs_dat_i[15:8];
    end

    unique case (state_q)
      S_IDLE: begin
        if (wr_fire && off == OFF_AP_CTRL && wbs_dat_i[0]) begin
          if (len_q != '0) begin
            state_d   = S_WAIT_X;
            mac_clear = 1'b1;
            cnt_d     = '0;
            done_clr  = 1'b1;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      S_WAIT_X: begin
        if (wr_fire && off == OFF_X_IN) begin
          mac_shift = 1'b1;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        if (mac_last) state_d = S_WAIT_Y;
      end
      S_WAIT_Y: begin
        if (rd_fire && off == OFF_Y_OUT) begin
          cnt_d = cnt_q + word_t'(1);
          if (cnt_d == len_q) begin
            done_set = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WAIT_X;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_fire) begin
      if (off == OFF_AP_CTRL) begin
        done_clr = 1'b1;
        dat_d = {26'b0, state_q == S_WAIT_Y, state_q == S_WAIT_X, 1'b0,
                 state_q == S_IDLE, done_q | done_set, 1'b0};
      end else if (off == OFF_DATA_LEN) begin
        dat_d = len_q;
      end else if (off == OFF_CHECKBITS) begin
        dat_d = {16'b0, chk_q};
      end else if (tap_hit) begin
        dat_d = taps_q[tap_sel];
      end else if (off == OFF_Y_OUT) begin
        dat_d = mac_y;
      end
    end

    // A set and a clear landing together leave ap_done set.
    done_d = done_set | (done_q & ~done_clr);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
      taps_q  <= '{default: '0};
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      taps_q  <= taps_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = chk_q;

`ifdef FIR_IRQ_EN
  assign irq_o = done_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_caravel_user_fir.sv
// Self-checking bench for caravel_user_fir: Wishbone master tasks plus a
// convolution reference model computed directly from y[n] = sum tap[i]*x[n-i].
module tb_caravel_user_fir;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [7:0]  AP = 8'h00, LEN = 8'h10, CHK = 8'h14, XIN = 8'h80, YOUT = 8'h84;
  localparam int          NT = 11;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] io_out;
  logic        irq;

  always #5 clk = ~clk;

  caravel_user_fir dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_out    (io_out),
    .irq_o     (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tap_m [NT];
  int xs [$];

`ifdef FIR_IRQ_EN
  localparam logic IRQ_ON_DONE = 1'b1;
`else
  localparam logic IRQ_ON_DONE = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One classic cycle; waited = edges until ack, or -1 if the limit expired.
  task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d,
                     input logic [3:0] s, input int limit,
                     output logic [31:0] q, output int waited);
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {24'b0, off}; wdat = d; sel = s;
    waited = -1;
    q = '0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        waited = i;
        q = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic reg_wr_sel(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    int w;
    bus(1'b1, off, d, s, 64, q, w);
    check($sformatf("wr ack @%02h", off), 32'(w > 0), 32'd1);
  endtask

  task automatic reg_wr(input logic [7:0] off, input logic [31:0] d);
    reg_wr_sel(off, d, 4'hF);
  endtask

  task automatic reg_rd(input logic [7:0] off, output logic [31:0] q);
    int w;
    bus(1'b0, off, '0, 4'hF, 64, q, w);
    check($sformatf("rd ack @%02h", off), 32'(w > 0), 32'd1);
  endtask

  task automatic expect_rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] q;
    reg_rd(off, q);
    check(tag, q, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic int model_y(input int n);
    int acc;
    acc = 0;
    for (int i = 0; i < NT; i++) if (n - i >= 0) acc += tap_m[i] * xs[n - i];
    return acc;
  endfunction

  task automatic set_tap(input int i, input int v);
    reg_wr(8'(8'h40 + 4 * i), v);
    tap_m[i] = v;
  endtask

  task automatic start(input int len);
    reg_wr(LEN, len);
    reg_wr(AP, 32'h1);
    xs.delete();
  endtask

  // Feed one sample, read its result and compare against the reference model.
  task automatic step(input int x, input string tag);
    logic [31:0] y;
    xs.push_back(x);
    reg_wr(XIN, x);
    reg_rd(YOUT, y);
    check($sformatf("%s y[%0d]", tag, xs.size() - 1), y, model_y(xs.size() - 1));
  endtask

  task automatic expect_done(input string tag);
    check({tag, " irq"}, 32'(irq), 32'(IRQ_ON_DONE));
    expect_rd({tag, " ap_ctrl done"}, AP, 32'h6);
    expect_rd({tag, " ap_ctrl cleared"}, AP, 32'h4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NT; i++) tap_m[i] = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    int          w, len;
    int          fig_taps [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    int          fig_y [5]     = '{0, -10, -29, -25, 35};
    logic [3:0]  s;
    logic [31:0] v;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    for (int i = 0; i < NT; i++) tap_m[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset ack", 32'(ack), 32'd0);
    check("reset dat", rdat, 32'd0);
    check("reset io_out", 32'(io_out), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    expect_rd("reset ap_ctrl", AP, 32'h4);
    bus(1'b0, YOUT, '0, 4'hF, 20, q, w);
    check("reset y_out stalls", w, -1);
    check("no double ack", 32'(ack), 32'd0);

    // Checkbits, including byte enables
    reg_wr(CHK, 32'h0000_AB40);
    check("io_out AB40", 32'(io_out), 32'hAB40);
    reg_wr_sel(CHK, 32'h1234_56CD, 4'b0001);
    check("io_out byte0", 32'(io_out), 32'hABCD);
    reg_wr(CHK, 32'h0000_AB51);
    check("io_out AB51", 32'(io_out), 32'hAB51);
    expect_rd("checkbits rd", CHK, 32'hAB51);

    // Unmapped offset
    reg_wr(8'h20, 32'hFFFF_FFFF);
    expect_rd("unmapped rd", 8'h20, 32'h0);

    // Documented coefficient set
    for (int i = 0; i < NT; i++) set_tap(i, fig_taps[i]);
    for (int i = 0; i < NT; i++)
      expect_rd($sformatf("tap%0d rd", i), 8'(8'h40 + 4 * i), fig_taps[i]);
    start(5);
    expect_rd("x_ready", AP, 32'h10);
    for (int n = 0; n < 5; n++) begin
      xs.push_back(n + 1);
      reg_wr(XIN, n + 1);
      reg_rd(YOUT, q);
      check($sformatf("fig y[%0d]", n), q, fig_y[n]);
    end
    expect_done("fig");

    // Impulse and latency: y_valid 12 cycles after the x ack, so a read held
    // from the ack onward is sampled on the 13th edge and acked after it.
    for (int i = 0; i < NT; i++) set_tap(i, i + 1);
    start(3);
    xs.push_back(1);
    reg_wr(XIN, 32'd1);
    bus(1'b0, YOUT, '0, 4'hF, 40, q, w);
    check("y latency", w, 13);
    check("impulse y[0]", q, 32'd1);
    step(0, "impulse");
    step(0, "impulse");
    expect_done("impulse");

    // Zero length completes immediately
    reg_wr(LEN, 32'd0);
    reg_wr(AP, 32'h1);
    expect_rd("len0 ap_ctrl", AP, 32'h6);
    expect_rd("len0 cleared", AP, 32'h4);

    // Writes while busy are ignored; checkbits still update
    for (int i = 0; i < NT; i++) set_tap(i, $urandom_range(0, 200) - 100);
    start(3);
    xs.push_back(7);
    reg_wr(XIN, 32'd7);
    reg_wr(AP, 32'h1);
    reg_wr(8'h40, 32'hDEAD_BEEF);
    reg_wr(LEN, 32'd1);
    reg_wr(CHK, 32'h0000_1234);
    check("busy checkbits", 32'(io_out), 32'h1234);
    reg_rd(YOUT, q);
    check("busy y[0]", q, model_y(0));
    step(-3, "busy");
    step(11, "busy");
    expect_done("busy");
    expect_rd("busy tap0 kept", 8'h40, tap_m[0]);
    expect_rd("busy len kept", LEN, 32'd3);

    // Randomised runs with full-range data and partial tap writes
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NT; i++) begin
        v = $urandom;
        s = (i % 3 == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
        reg_wr_sel(8'(8'h40 + 4 * i), v, s);
        tap_m[i] = merge(tap_m[i], v, s);
      end
      expect_rd($sformatf("rand%0d tap0 rd", r), 8'h40, tap_m[0]);
      len = $urandom_range(1, 6);
      start(len);
      for (int n = 0; n < len; n++) step($urandom, $sformatf("rand%0d", r));
      expect_done($sformatf("rand%0d", r));
    end

    // Reset in the middle of a MAC
    for (int i = 0; i < NT; i++) set_tap(i, 5 * i - 20);
    start(4);
    reg_wr(XIN, 32'd99);
    repeat (4) @(posedge clk);
    #1 do_reset();
    check("mid-reset ack", 32'(ack), 32'd0);
    check("mid-reset io_out", 32'(io_out), 32'd0);
    expect_rd("mid-reset ap_ctrl", AP, 32'h4);
    expect_rd("mid-reset len", LEN, 32'd0);
    expect_rd("mid-reset tap3", 8'h4C, 32'd0);
    bus(1'b0, YOUT, '0, 4'hF, 20, q, w);
    check("mid-reset y stalls", w, -1);
    for (int i = 0; i < NT; i++) set_tap(i, 3 - i);
    start(3);
    step(4, "post-reset");
    step(-6, "post-reset");
    step(9, "post-reset");
    expect_done("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
